multicycle_control: RTL

Main control FSM of CPU_MultiCycle. Sits directly upstream of the datapath: PC register, unified instruction/data memory, IR, register file and ALU. Consumes the 6-bit opcode latched in IR and produces every per-cycle datapath enable/select plus the 4-bit STATE. Moore machine. Also counts retired instructions for bench and debug use.

---
 rtl/cpu_ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_output_decode.sv | 127 ++++++++++++
 rtl/multicycle_control.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU_MultiCycle control path.
//   - opcode constants held in IR[31:26]
//   - 4-bit state encoding of the main control FSM
//   - ALUOp / ALUSrcB / PCSource encodings (also used by ALU control and the
//     datapath muxes)
//   - helper identifying states that retire an instruction
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcodes decoded by the main control FSM
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // FSM state encoding; codes 13..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // ALUOp encoding
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB encoding
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource encoding
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the last state of every legal instruction
  function automatic logic is_terminal(input state_t s);
    logic term_s;
    case (s)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: term_s = 1'b1;
      default:                                              term_s = 1'b0;
    endcase
    return term_s;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// -----------------------------------------------------------------------------
// ctrl_output_decode
// Purely combinational Moore decode: FSM state -> datapath control vector.
// While rst is low every write/read enable is forced to 0 so an aborted
// instruction cannot complete a write; selects keep their state decode
// (the FSM is held in FETCH during reset, so they show FETCH values).
// Ports:
//   state        in  4  current FSM state
//   rst          in  1  active-low reset, gates the enables
//   PCWrite .. illegal  out  control signals for the datapath
// -----------------------------------------------------------------------------
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       rst,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal
);

  logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
  logic ir_write_s, reg_write_s;

  // State lookup; unlisted signals stay 0
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    IorD            = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    reg_write_s     = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = SRCB_B;
    ALUOp           = ALUOP_ADD;
    PCSource        = PCSRC_ALU;
    illegal         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_s = 1'b1;
        ir_write_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        pc_write_s = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        IorD       = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        MemtoReg    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        IorD        = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        RegDst      = 1'b1;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA         = 1'b1;
        ALUOp           = ALUOP_SUB;
        pc_write_cond_s = 1'b1;
        PCSource        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        PCSource   = PCSRC_JUMP;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Reset gating of enables: combinational so an in-flight write drops at once
  always_comb begin
    if (rst) begin
      PCWrite     = pc_write_s;
      PCWriteCond = pc_write_cond_s;
      MemRead     = mem_read_s;
      MemWrite    = mem_write_s;
      IRWrite     = ir_write_s;
      RegWrite    = reg_write_s;
    end else begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main Moore control FSM of CPU_MultiCycle plus a retired-instruction counter.
// Ports:
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-low reset
//   OPCODE       in   6  IR[31:26], sampled in DECODE and MEMADR only
//   PCWrite .. PCSource   out  datapath enables/selects (decoded from state)
//   STATE        out  4  current state encoding
//   illegal      out  1  high while in HALT
//   instr_count  out 32  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OPCODE,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  STATE,
  output logic        illegal,
  output logic [31:0] instr_count
);

  state_t      state_r;
  logic [31:0] instr_count_r;

  // FSM transitions and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= S_FETCH;
      instr_count_r <= 32'd0;
    end else begin
      case (state_r)
        S_FETCH:  state_r <= S_DECODE;
        S_DECODE: begin
          case (OPCODE)
            OP_LW, OP_SW: state_r <= S_MEMADR;
            OP_RTYPE:     state_r <= S_EXEC;
            OP_BEQ:       state_r <= S_BRANCH;
            OP_J:         state_r <= S_JUMP;
            OP_ADDI:      state_r <= S_ADDIEX;
            default:      state_r <= S_HALT;
          endcase
        end
        // Only lw/sw reach MEMADR, so anything but sw is the load path
        S_MEMADR: begin
          if (OPCODE == OP_SW) begin
            state_r <= S_MEMWR;
          end else begin
            state_r <= S_MEMRD;
          end
        end
        S_MEMRD:  state_r <= S_MEMWB;
        S_EXEC:   state_r <= S_ALUWB;
        S_ADDIEX: state_r <= S_ADDIWB;
        S_HALT:   state_r <= S_HALT;
        // Terminal states and unused codes return to FETCH
        default:  state_r <= S_FETCH;
      endcase

      if (is_terminal(state_r)) begin
        instr_count_r <= instr_count_r + 32'd1;
      end else begin
        instr_count_r <= instr_count_r;
      end
    end
  end

  assign STATE       = state_r;
  assign instr_count = instr_count_r;

  ctrl_output_decode u_decode (
    .state       (state_r),
    .rst         (rst),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal     (illegal)
  );

endmodule
